seven_seg_to_bcd_capture: RTL and testbench

Receive-side counterpart of the BCD-to-seven-segment path. Samples a time-multiplexed seven-segment bus (active-low segments, active-low digit enables), qualifies each digit dwell for stability, and decodes the segment pattern back to BCD per digit slot. It sits in the self-check/loopback path of the display logic and reports captured digits, per-slot validity, a frame-complete pulse and a sticky decode error.

---
 rtl/seven_seg_to_bcd_capture.sv | 179 +++++++++++++++++
 tb/tb_seven_seg_to_bcd_capture.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_to_bcd_capture.sv
// Receive-side seven-segment capture: samples a multiplexed active-low segment
// bus, qualifies each digit dwell for stability and decodes it back to BCD.
module seven_seg_to_bcd_capture #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    err_clear,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_valid,
  output logic                    err_sticky
);

  localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned SLOT_W = $clog2(NUM_DIGITS);
  localparam int unsigned SMP_W  = NUM_DIGITS + 7;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [SMP_W-1:0]    sample_q;
  logic [SMP_W-1:0]    track_q, track_d;
  logic                sample_active;
  logic                commit;
  logic                commit_ok;
  logic [3:0]          commit_bcd;
  logic [SLOT_W-1:0]   commit_slot;
  logic [NUM_DIGITS-1:0] mask_q, mask_set, mask_merged;

  // Exactly one enable low marks a real digit slot; anything else is ghosting.
  function automatic logic one_low(input logic [NUM_DIGITS-1:0] an);
    int unsigned zeros;
    zeros = 0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) zeros++;
    end
    return (zeros == 1);
  endfunction

  function automatic logic [SLOT_W-1:0] slot_of(input logic [NUM_DIGITS-1:0] an);
    logic [SLOT_W-1:0] slot;
    slot = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) slot = SLOT_W'(i);
    end
    return slot;
  endfunction

  // Returns {ok, bcd}; blank display maps to 4'hF.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h01:   r = {1'b1, 4'h0};
      7'h4F:   r = {1'b1, 4'h1};
      7'h12:   r = {1'b1, 4'h2};
      7'h06:   r = {1'b1, 4'h3};
      7'h4C:   r = {1'b1, 4'h4};
      7'h24:   r = {1'b1, 4'h5};
      7'h20:   r = {1'b1, 4'h6};
      7'h0F:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h04:   r = {1'b1, 4'h9};
      7'h7F:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) sample_q <= '1;
    else          sample_q <= {an_in, seg_in};
  end

  assign sample_active = one_low(sample_q[SMP_W-1:7]);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      track_q <= '1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      track_q <= track_d;
    end
  end

  // The commit fires one edge after the count saturates, using the tracked
  // pattern, so the current sample does not affect what gets written.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    track_d = track_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_active) begin
          state_d = TRACK;
          count_d = CNT_W'(1);
          track_d = sample_q;
        end
      end
      TRACK: begin
        if (count_q == CNT_MAX) begin
          commit  = 1'b1;
          state_d = HOLD;
        end else if (!sample_active) begin
          state_d = IDLE;
          count_d = '0;
        end else if (sample_q == track_q) begin
          count_d = count_q + 1'b1;
        end else begin
          count_d = CNT_W'(1);
          track_d = sample_q;
        end
      end
      HOLD: begin
        if (sample_q != track_q) begin
          if (sample_active) begin
            state_d = TRACK;
            count_d = CNT_W'(1);
            track_d = sample_q;
          end else begin
            state_d = IDLE;
            count_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign {commit_ok, commit_bcd} = decode(track_q[6:0]);
  assign commit_slot = slot_of(track_q[SMP_W-1:7]);

  always_comb begin
    mask_set = '0;
    if (commit && commit_ok) mask_set = NUM_DIGITS'(1) << commit_slot;
    mask_merged = mask_q | mask_set;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      digits_out  <= '0;
      digit_valid <= '0;
      frame_valid <= 1'b0;
      err_sticky  <= 1'b0;
      mask_q      <= '0;
    end else begin
      if (commit && commit_ok) begin
        digits_out[4*commit_slot +: 4] <= commit_bcd;
        digit_valid[commit_slot]       <= 1'b1;
      end
      if (&mask_merged) begin
        frame_valid <= 1'b1;
        mask_q      <= '0;
      end else begin
        frame_valid <= 1'b0;
        mask_q      <= mask_merged;
      end
      if (commit && !commit_ok) err_sticky <= 1'b1;
      else if (err_clear)       err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seven_seg_to_bcd_capture.sv
// Directed self-checking bench for seven_seg_to_bcd_capture (4 slots, 4-cycle qualify).
module tb_seven_seg_to_bcd_capture;

  logic        clk;
  logic        reset_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic        err_clear;
  logic [15:0] digits_out;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        err_sticky;

  int checks;
  int failures;

  seven_seg_to_bcd_capture #(
    .NUM_DIGITS(4),
    .STABLE_CYCLES(4)
  ) dut (
    .clock(clk),
    .reset_n(reset_n),
    .seg_in(seg_in),
    .an_in(an_in),
    .err_clear(err_clear),
    .digits_out(digits_out),
    .digit_valid(digit_valid),
    .frame_valid(frame_valid),
    .err_sticky(err_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg);
    an_in  = an;
    seg_in = seg;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      seg_in    = 7'($urandom);
      an_in     = 4'($urandom);
      err_clear = 1'($urandom);
      tick(1);
    end
    err_clear = 1'b0;
    checks++;
    if ({digits_out, digit_valid, frame_valid, err_sticky} !== 22'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {digits_out, digit_valid, frame_valid, err_sticky});
    end
    // Pattern present during reset must not count toward qualification.
    drive(4'b1110, 7'h00);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    drive(4'b1111, 7'h7F);
    tick(6);
    checks++;
    if (digit_valid !== 4'b0000 || digits_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_no_early_commit got=%h/%h exp=0/0", digit_valid, digits_out);
    end
  endtask

  task automatic test_single_digit;
    drive(4'b1110, 7'h24);
    tick(4);
    drive(4'b1111, 7'h7F);
    tick(1);
    checks++;
    if (digit_valid !== 4'b0000) begin
      failures++;
      $display("FAIL single_early got=%b exp=0000", digit_valid);
    end
    tick(1);
    checks++;
    if (digits_out[3:0] !== 4'h5 || digit_valid !== 4'b0001) begin
      failures++;
      $display("FAIL single_commit got=%h/%b exp=5/0001", digits_out[3:0], digit_valid);
    end
    tick(2);
    drive(4'b1110, 7'h4F);
    tick(3);
    drive(4'b1111, 7'h7F);
    tick(6);
    checks++;
    if (digits_out[3:0] !== 4'h5) begin
      failures++;
      $display("FAIL single_short_dwell got=%h exp=5", digits_out[3:0]);
    end
  endtask

  task automatic run_sweep(output int pulses, output int pulse_at);
    logic [3:0] ans  [4];
    logic [6:0] segs [4];
    ans  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    segs = '{7'h4F, 7'h12, 7'h06, 7'h4C};
    pulses   = 0;
    pulse_at = -1;
    for (int k = 0; k < 4; k++) begin
      drive(ans[k], segs[k]);
      for (int j = 0; j < 6; j++) begin
        tick(1);
        if (frame_valid) begin
          pulses++;
          pulse_at = k * 6 + j;
        end
      end
    end
    drive(4'b1111, 7'h7F);
    for (int j = 0; j < 4; j++) begin
      tick(1);
      if (frame_valid) pulses++;
    end
  endtask

  task automatic test_frame;
    int pulses;
    int pulse_at;
    for (int s = 0; s < 2; s++) begin
      run_sweep(pulses, pulse_at);
      checks++;
      if (pulses != 1) begin
        failures++;
        $display("FAIL frame_pulse_count sweep=%0d got=%0d exp=1", s, pulses);
      end
      checks++;
      if (pulse_at != 23) begin
        failures++;
        $display("FAIL frame_pulse_cycle sweep=%0d got=%0d exp=23", s, pulse_at);
      end
      checks++;
      if (digits_out !== 16'h4321 || digit_valid !== 4'hF) begin
        failures++;
        $display("FAIL frame_digits sweep=%0d got=%h/%h exp=4321/f", s, digits_out, digit_valid);
      end
    end
  endtask

  task automatic test_error;
    drive(4'b1011, 7'h7E);
    tick(5);
    drive(4'b1111, 7'h7F);
    tick(1);
    checks++;
    if (err_sticky !== 1'b1 || digits_out !== 16'h4321 || digit_valid !== 4'hF) begin
      failures++;
      $display("FAIL error_set got=%b/%h/%h exp=1/4321/f", err_sticky, digits_out, digit_valid);
    end
    tick(2);
    drive(4'b1011, 7'h7E);
    tick(5);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    drive(4'b1111, 7'h7F);
    checks++;
    if (err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL error_set_wins got=%b exp=1", err_sticky);
    end
    tick(1);
    checks++;
    if (err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL error_sticky_hold got=%b exp=1", err_sticky);
    end
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    checks++;
    if (err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL error_clear got=%b exp=0", err_sticky);
    end
  endtask

  task automatic test_blank_ghost;
    drive(4'b1101, 7'h7F);
    tick(5);
    drive(4'b1111, 7'h7F);
    tick(1);
    checks++;
    if (digits_out !== 16'h43F1) begin
      failures++;
      $display("FAIL blank_decode got=%h exp=43f1", digits_out);
    end
    drive(4'b1100, 7'h00);
    tick(10);
    drive(4'b1111, 7'h7F);
    tick(3);
    checks++;
    if (digits_out !== 16'h43F1 || err_sticky !== 1'b0 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL ghost_ignored got=%h/%b/%b exp=43f1/0/0", digits_out, err_sticky, frame_valid);
    end
  endtask

  task automatic test_reset_mid_dwell;
    drive(4'b1110, 7'h00);
    tick(2);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    checks++;
    if (digits_out !== 16'h0000 || digit_valid !== 4'b0000 || err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_clear got=%h/%b/%b exp=0/0/0", digits_out, digit_valid, err_sticky);
    end
    tick(5);
    checks++;
    if (digit_valid !== 4'b0000 || digits_out !== 16'h0000) begin
      failures++;
      $display("FAIL mid_reset_discard got=%b/%h exp=0000/0", digit_valid, digits_out);
    end
    tick(1);
    checks++;
    if (digits_out !== 16'h0008 || digit_valid !== 4'b0001) begin
      failures++;
      $display("FAIL mid_reset_recommit got=%h/%b exp=0008/0001", digits_out, digit_valid);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    seg_in    = 7'h7F;
    an_in     = 4'b1111;
    err_clear = 1'b0;
    test_reset;
    test_single_digit;
    test_frame;
    test_error;
    test_blank_ghost;
    test_reset_mid_dwell;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
